// File: rtl/alu_rs_pkg.sv
// ============================================================================
// Module : tomasula_types
// Brief  : Shared types for the ALU reservation station slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tomasula_types;

    localparam int RS_DEPTH = 4;
    localparam int TAG_W    = 3;
    localparam int XLEN     = 32;

    typedef enum logic [2:0] {
        OP_BRANCH    = 3'd0,
        OP_ARITH     = 3'd1,
        OP_ARITH_IMM = 3'd2,
        OP_LUI       = 3'd3,
        OP_AUIPC     = 3'd4,
        OP_JAL       = 3'd5,
        OP_JALR      = 3'd6
    } alu_op_t;

    typedef struct packed {
        alu_op_t          op;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [TAG_W-1:0] src1_tag;
        logic [XLEN-1:0]  src1_data;
        logic             src1_valid;
        logic [TAG_W-1:0] src2_tag;
        logic [XLEN-1:0]  src2_data;
        logic             src2_valid;
        logic [TAG_W-1:0] rd;
        logic [XLEN-1:0]  imm;
    } alu_res_word;

    typedef struct packed {
        alu_op_t         op;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] src1_data;
        logic [XLEN-1:0] src2_data;
        logic [XLEN-1:0] imm;
    } alu_word;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } cdb_data;

    typedef struct packed {
        logic        busy;
        alu_res_word word;
    } rs_entry;

    // Fills any still-pending source whose tag matches a valid broadcast.
    function automatic alu_res_word cdb_capture(alu_res_word w, logic v, cdb_data c);
        alu_res_word r;
        r = w;
        if (v && !w.src1_valid && (w.src1_tag == c.tag)) begin
            r.src1_data  = c.data;
            r.src1_valid = 1'b1;
        end
        if (v && !w.src2_valid && (w.src2_tag == c.tag)) begin
            r.src2_data  = c.data;
            r.src2_valid = 1'b1;
        end
        return r;
    endfunction

    function automatic alu_word to_alu_word(alu_res_word w);
        alu_word a;
        a.op        = w.op;
        a.funct3    = w.funct3;
        a.funct7    = w.funct7;
        a.src1_data = w.src1_data;
        a.src2_data = w.src2_data;
        a.imm       = w.imm;
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rs_entry.sv
// ============================================================================
// Module : alu_rs_entry
// Brief  : One reservation-station slot: storage, CDB snoop, ready flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_rs_entry
    import tomasula_types::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_alloc,
    input  alu_res_word      i_word,
    input  logic             i_dispatch,
    input  logic             i_cdb_valid,
    input  cdb_data          i_cdb,
    output logic             o_busy,
    output logic             o_ready,
    output alu_word          o_alu,
    output logic [TAG_W-1:0] o_tag
);

    rs_entry r_entry;

    // Alloc and dispatch never target the same slot: alloc needs !busy, dispatch needs ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_entry <= '0;
        end else if (i_flush) begin
            r_entry.busy <= 1'b0;
        end else if (i_alloc) begin
            r_entry <= {1'b1, i_word};
        end else if (i_dispatch) begin
            r_entry.busy <= 1'b0;
        end else if (r_entry.busy) begin
            r_entry.word <= cdb_capture(r_entry.word, i_cdb_valid, i_cdb);
        end
    end

    assign o_busy  = r_entry.busy;
    assign o_ready = r_entry.busy && r_entry.word.src1_valid && r_entry.word.src2_valid;
    assign o_alu   = to_alu_word(r_entry.word);
    assign o_tag   = r_entry.word.rd;

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
// ============================================================================
// Module : alu_rs
// Brief  : ALU reservation station; wakes on CDB, dispatches one word/cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_rs
    import tomasula_types::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_issue_valid,
    input  alu_res_word      i_issue_word,
    output logic             o_rs_full,
    input  logic             i_cdb_valid,
    input  cdb_data          i_cdb,
    output logic             o_alu_valid,
    input  logic             i_alu_ready,
    output alu_word          o_alu_out,
    output logic [TAG_W-1:0] o_alu_tag
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] w_busy;
    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_alloc;
    logic [DEPTH-1:0] w_dispatch;
    alu_word          w_ent_alu [DEPTH];
    logic [TAG_W-1:0] w_ent_tag [DEPTH];
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_any_ready;
    logic             w_do_issue;
    logic             w_load;
    alu_res_word      w_issue_byp;

    logic             r_alu_valid;
    alu_word          r_alu_out;
    logic [TAG_W-1:0] r_alu_tag;

    assign o_rs_full   = &w_busy;
    assign w_do_issue  = i_issue_valid && !o_rs_full;
    assign w_any_ready = |w_ready;
    assign w_load      = (!r_alu_valid || i_alu_ready) && w_any_ready;
    assign w_issue_byp = cdb_capture(i_issue_word, i_cdb_valid, i_cdb);

    // Descending scans so the lowest matching index wins.
    always_comb begin
        w_free_idx = '0;
        w_sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_busy[i]) w_free_idx = IDX_W'(i);
            if (w_ready[i]) w_sel_idx  = IDX_W'(i);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        assign w_alloc[k]    = w_do_issue && (w_free_idx == IDX_W'(k));
        assign w_dispatch[k] = w_load && (w_sel_idx == IDX_W'(k));

        alu_rs_entry u_entry (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (i_flush),
            .i_alloc     (w_alloc[k]),
            .i_word      (w_issue_byp),
            .i_dispatch  (w_dispatch[k]),
            .i_cdb_valid (i_cdb_valid),
            .i_cdb       (i_cdb),
            .o_busy      (w_busy[k]),
            .o_ready     (w_ready[k]),
            .o_alu       (w_ent_alu[k]),
            .o_tag       (w_ent_tag[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_valid <= 1'b0;
            r_alu_out   <= '0;
            r_alu_tag   <= '0;
        end else if (i_flush) begin
            r_alu_valid <= 1'b0;
        end else if (w_load) begin
            r_alu_valid <= 1'b1;
            r_alu_out   <= w_ent_alu[w_sel_idx];
            r_alu_tag   <= w_ent_tag[w_sel_idx];
        end else if (i_alu_ready) begin
            r_alu_valid <= 1'b0;
        end
    end

    assign o_alu_valid = r_alu_valid;
    assign o_alu_out   = r_alu_out;
    assign o_alu_tag   = r_alu_tag;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ============================================================================
// Module : tb_alu_rs
// Brief  : Scoreboard bench for alu_rs with a slot-array reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_rs;
    import tomasula_types::*;

    localparam int D = 4;

    typedef struct packed {
        alu_word    w;
        logic [2:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    alu_res_word iw = '0;
    logic        rs_full;
    logic        cdb_valid = 1'b0;
    cdb_data     cdb = '0;
    logic        alu_valid;
    logic        alu_ready = 1'b1;
    alu_word     alu_out;
    logic [2:0]  alu_tag;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    bit          m_busy [D];
    alu_res_word m_word [D];
    bit          m_outv = 0;
    exp_t        q [$];

    alu_rs #(.DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (flush),
        .i_issue_valid (issue_valid),
        .i_issue_word  (iw),
        .o_rs_full     (rs_full),
        .i_cdb_valid   (cdb_valid),
        .i_cdb         (cdb),
        .o_alu_valid   (alu_valid),
        .i_alu_ready   (alu_ready),
        .o_alu_out     (alu_out),
        .o_alu_tag     (alu_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic alu_res_word snoop(alu_res_word w, logic v, cdb_data c);
        alu_res_word r = w;
        if (v && !r.src1_valid && r.src1_tag == c.tag) begin r.src1_data = c.data; r.src1_valid = 1; end
        if (v && !r.src2_valid && r.src2_tag == c.tag) begin r.src2_data = c.data; r.src2_valid = 1; end
        return r;
    endfunction

    function automatic bit m_full();
        bit f = 1;
        for (int i = 0; i < D; i++) if (!m_busy[i]) f = 0;
        return f;
    endfunction

    // Advances the model across one edge using the inputs held before it.
    task automatic model_step();
        int fr = -1;
        int sl = -1;
        bit full;
        exp_t e;
        if (!rst || flush) begin
            for (int i = 0; i < D; i++) m_busy[i] = 0;
            m_outv = 0;
            q.delete();
            return;
        end
        for (int i = 0; i < D; i++) begin
            if (!m_busy[i] && fr < 0) fr = i;
            if (m_busy[i] && m_word[i].src1_valid && m_word[i].src2_valid && sl < 0) sl = i;
        end
        full = (fr < 0);
        if ((!m_outv || alu_ready) && sl >= 0) begin
            e.w   = '{op: m_word[sl].op, funct3: m_word[sl].funct3, funct7: m_word[sl].funct7,
                      src1_data: m_word[sl].src1_data, src2_data: m_word[sl].src2_data,
                      imm: m_word[sl].imm};
            e.tag = m_word[sl].rd;
            q.push_back(e);
            m_busy[sl] = 0;
            m_outv = 1;
        end else if (alu_ready) begin
            m_outv = 0;
        end
        for (int i = 0; i < D; i++) if (m_busy[i]) m_word[i] = snoop(m_word[i], cdb_valid, cdb);
        if (issue_valid && !full) begin
            m_word[fr] = snoop(iw, cdb_valid, cdb);
            m_busy[fr] = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        issue_valid = 0;
        cdb_valid   = 0;
        flush       = 0;
    endtask

    function automatic alu_res_word mk(alu_op_t op, logic v1, logic [2:0] t1, logic [31:0] d1,
                                       logic v2, logic [2:0] t2, logic [31:0] d2, logic [2:0] rd);
        alu_res_word w;
        w.op = op; w.funct3 = 3'($urandom); w.funct7 = 7'($urandom); w.imm = $urandom;
        w.src1_valid = v1; w.src1_tag = t1; w.src1_data = d1;
        w.src2_valid = v2; w.src2_tag = t2; w.src2_data = d2;
        w.rd = rd;
        return w;
    endfunction

    task automatic issue(alu_res_word w);
        issue_valid = 1;
        iw = w;
    endtask

    task automatic bcast(logic [2:0] t, logic [31:0] d);
        cdb_valid = 1;
        cdb.tag = t;
        cdb.data = d;
    endtask

    // Monitor: cycle-level state checks plus scoreboard pop on each ALU handshake.
    always @(negedge clk) begin
        if (started) begin
            exp_t e;
            chk("rs_full", {127'd0, rs_full}, {127'd0, m_full()});
            chk("alu_valid", {127'd0, alu_valid}, {127'd0, m_outv});
            if (alu_valid && alu_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_dispatch", 128'd1, 128'd0);
                end else begin
                    e = q.pop_front();
                    chk("alu_out", {19'd0, alu_out}, {19'd0, e.w});
                    chk("alu_tag", {125'd0, alu_tag}, {125'd0, e.tag});
                end
            end
        end
    end

    initial begin
        alu_word held;
        cyc();
        cyc();
        started = 1;
        rst = 1;
        chk("rst_valid", {127'd0, alu_valid}, 128'd0);
        chk("rst_full", {127'd0, rs_full}, 128'd0);
        chk("rst_out", {19'd0, alu_out}, 128'd0);
        chk("rst_tag", {125'd0, alu_tag}, 128'd0);

        // Both operands valid: one cycle from write to alu_valid.
        issue(mk(OP_ARITH, 1, 0, 5, 1, 0, 7, 3));
        cyc();
        cyc();
        chk("t1_valid", {127'd0, alu_valid}, 128'd1);
        chk("t1_src1", {96'd0, alu_out.src1_data}, 128'd5);
        chk("t1_src2", {96'd0, alu_out.src2_data}, 128'd7);
        chk("t1_tag", {125'd0, alu_tag}, 128'd3);

        // Late operand via CDB two cycles after issue.
        issue(mk(OP_ARITH, 0, 2, 0, 1, 0, 9, 1));
        cyc();
        cyc();
        bcast(2, 32'hDEADBEEF);
        cyc();
        chk("t2_wait", {127'd0, alu_valid}, 128'd0);
        cyc();
        chk("t2_valid", {127'd0, alu_valid}, 128'd1);
        chk("t2_src1", {96'd0, alu_out.src1_data}, 128'hDEADBEEF);

        // Broadcast in the issue cycle is captured on the way in.
        issue(mk(OP_ARITH, 1, 0, 4, 0, 6, 0, 2));
        bcast(6, 32'h11);
        cyc();
        cyc();
        chk("t3_valid", {127'd0, alu_valid}, 128'd1);
        chk("t3_src2", {96'd0, alu_out.src2_data}, 128'h11);
        cyc();
        cyc();

        // Fill with unresolved entries, wake entry 2 only.
        for (int k = 0; k < D; k++) begin
            issue(mk(OP_ARITH_IMM, 0, 3'(k + 1), 0, 1, 0, 0, 3'(k + 4)));
            cyc();
        end
        chk("t4_full", {127'd0, rs_full}, 128'd1);
        alu_ready = 0;
        bcast(3, 32'h33);
        cyc();
        chk("t4_full_capture", {127'd0, rs_full}, 128'd1);
        cyc();
        chk("t4_valid", {127'd0, alu_valid}, 128'd1);
        chk("t4_tag", {125'd0, alu_tag}, 128'd6);
        chk("t4_full_fall", {127'd0, rs_full}, 128'd0);

        // Flush with three busy entries and a stalled output.
        flush = 1;
        cyc();
        chk("t6_valid", {127'd0, alu_valid}, 128'd0);
        chk("t6_full", {127'd0, rs_full}, 128'd0);
        alu_ready = 1;
        bcast(1, 1); cyc();
        bcast(2, 2); cyc();
        bcast(4, 4); cyc();
        cyc();
        chk("t6_no_dispatch", {127'd0, alu_valid}, 128'd0);

        // Stall with waiting ready entries; slot 0 (C) must beat slot 1 (B).
        alu_ready = 0;
        issue(mk(OP_LUI, 1, 0, 1, 1, 0, 1, 1)); cyc();
        issue(mk(OP_LUI, 1, 0, 2, 1, 0, 2, 2)); cyc();
        issue(mk(OP_LUI, 1, 0, 3, 1, 0, 3, 3)); cyc();
        held = alu_out;
        chk("t5_tag_a", {125'd0, alu_tag}, 128'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_stable", {19'd0, alu_out}, {19'd0, held});
        end
        alu_ready = 1;
        cyc();
        chk("t5_tag_c", {125'd0, alu_tag}, 128'd3);
        cyc();
        chk("t5_tag_b", {125'd0, alu_tag}, 128'd2);
        cyc();
        chk("t5_drain", {127'd0, alu_valid}, 128'd0);

        // Randomized traffic checked by the monitor.
        for (int n = 0; n < 4000; n++) begin
            alu_ready = ($urandom_range(0, 3) != 0);
            if (!m_full() && $urandom_range(0, 1) == 1)
                issue(mk(alu_op_t'($urandom_range(0, 6)), 1'($urandom), 3'($urandom), $urandom,
                         1'($urandom), 3'($urandom), $urandom, 3'($urandom)));
            if ($urandom_range(0, 1) == 1) bcast(3'($urandom), $urandom);
            flush = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 299) != 0);
            cyc();
            rst = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_rs.md
# alu_rs

ALU reservation station for the Tomasulo core. It accepts renamed ALU-class instructions (`alu_res_word`) from the issue stage and holds them until both operands are valid, capturing missing operands by snooping the common data bus. It then dispatches one ready instruction per cycle to the ALU as an `alu_word` plus its ROB destination tag. It sits between issue/rename (upstream) and the ALU (downstream).

## Interface
- `DEPTH`, default 4: number of station entries; legal range 2–8.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `flush` in 1: mispredict flush; drops all entries and the output register.
- `issue_valid` in 1: `issue_word` is valid this cycle.
- `issue_word` in `alu_res_word`: op, funct3, funct7, src tags/data/valid, `rd` (ROB tag), imm.
- `rs_full` out 1: no free entry; issue must not assert `issue_valid` while high.
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb` in `cdb_data`: 3-bit tag and 32-bit data.
- `alu_valid` out 1: `alu_out`/`alu_tag` hold an instruction for the ALU.
- `alu_ready` in 1: ALU accepts the word this cycle.
- `alu_out` out `alu_word`: op, funct3, funct7, src1_data, src2_data, imm.
- `alu_tag` out 3: ROB tag (`rd`) of the dispatched instruction.

## Operation
- Each entry holds a busy bit plus an `alu_res_word`. An entry is ready when busy && src1_valid && src2_valid.
- Issue sets src2_valid=1 for immediate/AUIPC/JAL forms that have no second register. It sets src1_data=PC, valid, where the op needs it.
- Allocation: when issue_valid && !rs_full, write to the lowest-index non-busy entry and set busy.
- Issue with issue_valid while rs_full: word ignored; bench flags it as an assertion failure.
- `rs_full` is combinational: all entries busy. It does not account for a same-cycle dispatch freeing a slot.
- CDB snoop, per entry and per source: if busy && !srcN_valid && cdb_valid && cdb.tag==srcN_tag, latch cdb.data and set srcN_valid.
- Issue-cycle bypass: the same match is applied to the incoming `issue_word`, so an operand broadcast in the issue cycle is never missed.
- Output register load condition: `!alu_valid || alu_ready`, and at least one ready entry.
- Dispatch selection: load the lowest-index ready entry into `alu_out`/`alu_tag`, clear its busy bit the same edge, and set `alu_valid`.
- If the load condition holds but no entry is ready, `alu_valid` clears when `alu_ready` is high. The output holds unchanged otherwise.
- While `alu_valid && !alu_ready`, `alu_out` and `alu_tag` are stable.
- An entry freed by dispatch is allocatable from the next cycle.
- Priority: reset > flush > normal operation.
- Flush: all busy=0 and alu_valid=0 next edge. Same-cycle issue and CDB capture are discarded.

## Timing
- Reset values: every entry busy=0; `alu_valid`=0; `alu_out` all zero (op=BRANCH encoding 0); `alu_tag`=0; `rs_full`=0.
- Issue at edge N with both operands valid → ready from N. `alu_valid` is high after edge N+1 if the output is free; minimum latency is 1 cycle from write.
- CDB capture at edge N → entry ready from N → dispatched at edge N+1.
- Throughput: one dispatch per cycle while `alu_ready` stays high and ready entries exist.
- Simultaneous dispatch of entry k and issue: the issue uses a slot free before the edge, never slot k.
- Simultaneous CDB and issue: the issued word is written with the broadcast operand already captured.
- Reset or flush mid-stall: the output is dropped; the ALU must not consume on the following cycle.

## Structure
- Shared package `tomasula_types` gains:
  - `RS_DEPTH` default constant.
  - `TAG_W`=3.
  - `rs_entry` struct: busy plus `alu_res_word` fields.
- One natural sub-module: `alu_rs_entry`, holding a single entry's storage, CDB snoop/capture, and ready flag.
- The top level holds:
  - the free-slot priority encoder;
  - the ready-entry priority encoder;
  - the output register.

## Test plan
- Reset, then issue ARITH with src1=5, src2=7 both valid, rd=3 → next cycle `alu_valid`=1, src1_data=5, src2_data=7, `alu_tag`=3.
- Issue with src1_valid=0, src1_tag=2; two cycles later CDB tag=2, data=0xDEADBEEF → dispatch one cycle after the broadcast with src1_data=0xDEADBEEF.
- Issue in the same cycle as a matching CDB (tag 6, data 0x11) → entry stored valid, dispatched next cycle with 0x11.
- Fill 4 entries with unresolved operands → `rs_full`=1; broadcast the tag that resolves entry 2 → entry 2 dispatched and `rs_full` falls the following cycle.
- Hold `alu_ready`=0 for 3 cycles with 2 ready entries → `alu_out` is stable; on release, entries dispatch on consecutive cycles, lowest index first.
- Assert `flush` with 3 busy entries and `alu_valid`=1 → next cycle `alu_valid`=0, `rs_full`=0, no later dispatch of the flushed entries.
